// File: rtl/dca_matrix_slx_arbiter.sv
// Shares one SLX slave port among the ma/mb/mc requesters: packet-granular request
// arbitration plus an in-order ID queue that routes responses. Macro DCA_MATRIX_SLX_ARB_RR_EN selects round-robin.
module dca_matrix_slx_arbiter #(
  parameter int BW_ADDR           = 32,
  parameter int BW_DATA           = 128,
  parameter int BW_BURDEN         = 1,
  parameter int OUTSTANDING_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rstnn,
  // requester a
  input  logic                   ma_slxqvalid,
  input  logic                   ma_slxqlast,
  input  logic                   ma_slxqwrite,
  input  logic [7:0]             ma_slxqlen,
  input  logic [2:0]             ma_slxqsize,
  input  logic [1:0]             ma_slxqburst,
  input  logic [BW_DATA/8-1:0]   ma_slxqwstrb,
  input  logic [BW_DATA-1:0]     ma_slxqwdata,
  input  logic [BW_ADDR-1:0]     ma_slxqaddr,
  input  logic [BW_BURDEN-1:0]   ma_slxqburden,
  output logic [1:0]             ma_slxqdready,
  output logic                   ma_slxyvalid,
  output logic                   ma_slxylast,
  output logic                   ma_slxywreply,
  output logic [1:0]             ma_slxyresp,
  output logic [BW_DATA-1:0]     ma_slxyrdata,
  output logic [BW_BURDEN-1:0]   ma_slxyburden,
  input  logic [1:0]             ma_slxydready,
  // requester b
  input  logic                   mb_slxqvalid,
  input  logic                   mb_slxqlast,
  input  logic                   mb_slxqwrite,
  input  logic [7:0]             mb_slxqlen,
  input  logic [2:0]             mb_slxqsize,
  input  logic [1:0]             mb_slxqburst,
  input  logic [BW_DATA/8-1:0]   mb_slxqwstrb,
  input  logic [BW_DATA-1:0]     mb_slxqwdata,
  input  logic [BW_ADDR-1:0]     mb_slxqaddr,
  input  logic [BW_BURDEN-1:0]   mb_slxqburden,
  output logic [1:0]             mb_slxqdready,
  output logic                   mb_slxyvalid,
  output logic                   mb_slxylast,
  output logic                   mb_slxywreply,
  output logic [1:0]             mb_slxyresp,
  output logic [BW_DATA-1:0]     mb_slxyrdata,
  output logic [BW_BURDEN-1:0]   mb_slxyburden,
  input  logic [1:0]             mb_slxydready,
  // requester c
  input  logic                   mc_slxqvalid,
  input  logic                   mc_slxqlast,
  input  logic                   mc_slxqwrite,
  input  logic [7:0]             mc_slxqlen,
  input  logic [2:0]             mc_slxqsize,
  input  logic [1:0]             mc_slxqburst,
  input  logic [BW_DATA/8-1:0]   mc_slxqwstrb,
  input  logic [BW_DATA-1:0]     mc_slxqwdata,
  input  logic [BW_ADDR-1:0]     mc_slxqaddr,
  input  logic [BW_BURDEN-1:0]   mc_slxqburden,
  output logic [1:0]             mc_slxqdready,
  output logic                   mc_slxyvalid,
  output logic                   mc_slxylast,
  output logic                   mc_slxywreply,
  output logic [1:0]             mc_slxyresp,
  output logic [BW_DATA-1:0]     mc_slxyrdata,
  output logic [BW_BURDEN-1:0]   mc_slxyburden,
  input  logic [1:0]             mc_slxydready,
  // slave side
  output logic                   s_slxqvalid,
  output logic                   s_slxqlast,
  output logic                   s_slxqwrite,
  output logic [7:0]             s_slxqlen,
  output logic [2:0]             s_slxqsize,
  output logic [1:0]             s_slxqburst,
  output logic [BW_DATA/8-1:0]   s_slxqwstrb,
  output logic [BW_DATA-1:0]     s_slxqwdata,
  output logic [BW_ADDR-1:0]     s_slxqaddr,
  output logic [BW_BURDEN-1:0]   s_slxqburden,
  input  logic [1:0]             s_slxqdready,
  input  logic                   s_slxyvalid,
  input  logic                   s_slxylast,
  input  logic                   s_slxywreply,
  input  logic [1:0]             s_slxyresp,
  input  logic [BW_DATA-1:0]     s_slxyrdata,
  input  logic [BW_BURDEN-1:0]   s_slxyburden,
  output logic [1:0]             s_slxydready
);

  localparam int PW = $clog2(OUTSTANDING_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state, state_nxt;
  logic [1:0]    grant, grant_nxt;
  logic [1:0]    winner;
  logic [2:0]    req;
  logic          sel_valid;
  logic          q_fire, push, y_fire, pop;
  logic          empty, full;
  logic [1:0]    head;
  logic [1:0]    id_q [OUTSTANDING_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  assign req = {mc_slxqvalid, mb_slxqvalid, ma_slxqvalid};

`ifdef DCA_MATRIX_SLX_ARB_RR_EN
  logic [1:0] rr_ptr;

  function automatic logic [1:0] next_id(input logic [1:0] id);
    next_id = (id == 2'd2) ? 2'd0 : id + 2'd1;
  endfunction

  // Reverse scan so the requester closest to the pointer overwrites the others.
  function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] ptr);
    logic [1:0] idx;
    rr_pick = ptr;
    for (int k = 2; k >= 0; k--) begin
      idx = 2'((int'(ptr) + k) % 3);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  assign winner = rr_pick(req, rr_ptr);

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn)
      rr_ptr <= 2'd0;
    else if (state == IDLE && state_nxt == GRANT)
      rr_ptr <= next_id(winner);
  end
`else
  assign winner = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
`endif

  assign empty = (count == '0);
  assign full  = (count == CW'(OUTSTANDING_DEPTH));
  assign head  = id_q[rd_ptr];

  // Arbitration FSM
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    case (state)
      IDLE: begin
        if (!full && (|req)) begin
          grant_nxt = winner;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (push) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      state <= IDLE;
      grant <= 2'd0;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
    end
  end

  // Request channel mux
  always_comb begin
    sel_valid    = ma_slxqvalid;
    s_slxqlast   = ma_slxqlast;
    s_slxqwrite  = ma_slxqwrite;
    s_slxqlen    = ma_slxqlen;
    s_slxqsize   = ma_slxqsize;
    s_slxqburst  = ma_slxqburst;
    s_slxqwstrb  = ma_slxqwstrb;
    s_slxqwdata  = ma_slxqwdata;
    s_slxqaddr   = ma_slxqaddr;
    s_slxqburden = ma_slxqburden;
    if (grant == 2'd1) begin
      sel_valid    = mb_slxqvalid;
      s_slxqlast   = mb_slxqlast;
      s_slxqwrite  = mb_slxqwrite;
      s_slxqlen    = mb_slxqlen;
      s_slxqsize   = mb_slxqsize;
      s_slxqburst  = mb_slxqburst;
      s_slxqwstrb  = mb_slxqwstrb;
      s_slxqwdata  = mb_slxqwdata;
      s_slxqaddr   = mb_slxqaddr;
      s_slxqburden = mb_slxqburden;
    end else if (grant == 2'd2) begin
      sel_valid    = mc_slxqvalid;
      s_slxqlast   = mc_slxqlast;
      s_slxqwrite  = mc_slxqwrite;
      s_slxqlen    = mc_slxqlen;
      s_slxqsize   = mc_slxqsize;
      s_slxqburst  = mc_slxqburst;
      s_slxqwstrb  = mc_slxqwstrb;
      s_slxqwdata  = mc_slxqwdata;
      s_slxqaddr   = mc_slxqaddr;
      s_slxqburden = mc_slxqburden;
    end
  end

  assign s_slxqvalid   = (state == GRANT) && sel_valid;
  assign ma_slxqdready = (state == GRANT && grant == 2'd0) ? s_slxqdready : 2'b00;
  assign mb_slxqdready = (state == GRANT && grant == 2'd1) ? s_slxqdready : 2'b00;
  assign mc_slxqdready = (state == GRANT && grant == 2'd2) ? s_slxqdready : 2'b00;

  assign q_fire = s_slxqvalid && s_slxqdready[s_slxqwrite];
  assign push   = q_fire && s_slxqlast;

  // ID queue
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) id_q[wr_ptr] <= grant;
  end

  // Response routing by queue head
  always_comb begin
    s_slxydready = 2'b00;
    if (!empty) begin
      case (head)
        2'd0:    s_slxydready = ma_slxydready;
        2'd1:    s_slxydready = mb_slxydready;
        default: s_slxydready = mc_slxydready;
      endcase
    end
  end

  assign y_fire = s_slxyvalid && s_slxydready[s_slxywreply];
  assign pop    = y_fire && (s_slxywreply || s_slxylast);

  assign ma_slxyvalid = s_slxyvalid && !empty && (head == 2'd0);
  assign mb_slxyvalid = s_slxyvalid && !empty && (head == 2'd1);
  assign mc_slxyvalid = s_slxyvalid && !empty && (head == 2'd2);

  assign ma_slxylast   = s_slxylast;
  assign mb_slxylast   = s_slxylast;
  assign mc_slxylast   = s_slxylast;
  assign ma_slxywreply = s_slxywreply;
  assign mb_slxywreply = s_slxywreply;
  assign mc_slxywreply = s_slxywreply;
  assign ma_slxyresp   = s_slxyresp;
  assign mb_slxyresp   = s_slxyresp;
  assign mc_slxyresp   = s_slxyresp;
  assign ma_slxyrdata  = s_slxyrdata;
  assign mb_slxyrdata  = s_slxyrdata;
  assign mc_slxyrdata  = s_slxyrdata;
  assign ma_slxyburden = s_slxyburden;
  assign mb_slxyburden = s_slxyburden;
  assign mc_slxyburden = s_slxyburden;

endmodule

// File: tb/tb_dca_matrix_slx_arbiter.sv
// Directed bench for dca_matrix_slx_arbiter: grant order, write-burst hold,
// queue-full blocking, in-order response routing and asynchronous reset.
module tb_dca_matrix_slx_arbiter;

  logic clk = 1'b0;
  logic rstnn;

  logic         qv [3], ql [3], qw [3];
  logic [7:0]   qlen [3];
  logic [2:0]   qsize [3];
  logic [1:0]   qburst [3];
  logic [15:0]  qwstrb [3];
  logic [127:0] qwdata [3];
  logic [31:0]  qaddr [3];
  logic [0:0]   qburden [3];
  logic [1:0]   qdr [3];
  logic         yv [3], yl [3], ywr [3];
  logic [1:0]   yresp [3];
  logic [127:0] yrdata [3];
  logic [0:0]   yburden [3];
  logic [1:0]   ydr [3];

  logic         s_qvalid, s_qlast, s_qwrite;
  logic [7:0]   s_qlen;
  logic [2:0]   s_qsize;
  logic [1:0]   s_qburst;
  logic [15:0]  s_qwstrb;
  logic [127:0] s_qwdata;
  logic [31:0]  s_qaddr;
  logic [0:0]   s_qburden;
  logic [1:0]   s_qdready;
  logic         s_yvalid, s_ylast, s_ywreply;
  logic [1:0]   s_yresp;
  logic [127:0] s_yrdata;
  logic [0:0]   s_yburden;
  logic [1:0]   s_ydready;

  int n_assert = 0;
  int n_fail   = 0;

  dca_matrix_slx_arbiter #(
    .BW_ADDR(32), .BW_DATA(128), .BW_BURDEN(1), .OUTSTANDING_DEPTH(4)
  ) dut (
    .clk(clk), .rstnn(rstnn),
    .ma_slxqvalid(qv[0]), .ma_slxqlast(ql[0]), .ma_slxqwrite(qw[0]), .ma_slxqlen(qlen[0]),
    .ma_slxqsize(qsize[0]), .ma_slxqburst(qburst[0]), .ma_slxqwstrb(qwstrb[0]),
    .ma_slxqwdata(qwdata[0]), .ma_slxqaddr(qaddr[0]), .ma_slxqburden(qburden[0]),
    .ma_slxqdready(qdr[0]), .ma_slxyvalid(yv[0]), .ma_slxylast(yl[0]), .ma_slxywreply(ywr[0]),
    .ma_slxyresp(yresp[0]), .ma_slxyrdata(yrdata[0]), .ma_slxyburden(yburden[0]),
    .ma_slxydready(ydr[0]),
    .mb_slxqvalid(qv[1]), .mb_slxqlast(ql[1]), .mb_slxqwrite(qw[1]), .mb_slxqlen(qlen[1]),
    .mb_slxqsize(qsize[1]), .mb_slxqburst(qburst[1]), .mb_slxqwstrb(qwstrb[1]),
    .mb_slxqwdata(qwdata[1]), .mb_slxqaddr(qaddr[1]), .mb_slxqburden(qburden[1]),
    .mb_slxqdready(qdr[1]), .mb_slxyvalid(yv[1]), .mb_slxylast(yl[1]), .mb_slxywreply(ywr[1]),
    .mb_slxyresp(yresp[1]), .mb_slxyrdata(yrdata[1]), .mb_slxyburden(yburden[1]),
    .mb_slxydready(ydr[1]),
    .mc_slxqvalid(qv[2]), .mc_slxqlast(ql[2]), .mc_slxqwrite(qw[2]), .mc_slxqlen(qlen[2]),
    .mc_slxqsize(qsize[2]), .mc_slxqburst(qburst[2]), .mc_slxqwstrb(qwstrb[2]),
    .mc_slxqwdata(qwdata[2]), .mc_slxqaddr(qaddr[2]), .mc_slxqburden(qburden[2]),
    .mc_slxqdready(qdr[2]), .mc_slxyvalid(yv[2]), .mc_slxylast(yl[2]), .mc_slxywreply(ywr[2]),
    .mc_slxyresp(yresp[2]), .mc_slxyrdata(yrdata[2]), .mc_slxyburden(yburden[2]),
    .mc_slxydready(ydr[2]),
    .s_slxqvalid(s_qvalid), .s_slxqlast(s_qlast), .s_slxqwrite(s_qwrite), .s_slxqlen(s_qlen),
    .s_slxqsize(s_qsize), .s_slxqburst(s_qburst), .s_slxqwstrb(s_qwstrb),
    .s_slxqwdata(s_qwdata), .s_slxqaddr(s_qaddr), .s_slxqburden(s_qburden),
    .s_slxqdready(s_qdready), .s_slxyvalid(s_yvalid), .s_slxylast(s_ylast),
    .s_slxywreply(s_ywreply), .s_slxyresp(s_yresp), .s_slxyrdata(s_yrdata),
    .s_slxyburden(s_yburden), .s_slxydready(s_ydready)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #2;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_req(input int i);
    qv[i] = 1'b0; ql[i] = 1'b0; qw[i] = 1'b0; qlen[i] = 8'd0; qsize[i] = 3'd0;
    qburst[i] = 2'd0; qwstrb[i] = 16'd0; qwdata[i] = '0; qaddr[i] = '0; qburden[i] = 1'b0;
  endtask

  task automatic set_read(input int i, input logic [31:0] addr);
    qv[i] = 1'b1; ql[i] = 1'b1; qw[i] = 1'b0; qlen[i] = 8'd0; qaddr[i] = addr;
  endtask

  // Lone requester single-beat read from an IDLE-aligned cycle; leaves arbiter IDLE.
  task automatic issue_read(input int i, input logic [31:0] addr);
    set_read(i, addr);
    tick;
    settle;
    chk("issue_qvalid", s_qvalid, 1'b1);
    chk("issue_addr", s_qaddr, addr);
    chk("issue_qdready", qdr[i], 2'b11);
    tick;
    clr_req(i);
  endtask

  function automatic logic [2:0] yvec();
    return {yv[2], yv[1], yv[0]};
  endfunction

  function automatic logic [2:0] qdr_any();
    return {|qdr[2], |qdr[1], |qdr[0]};
  endfunction

  logic [31:0] got [6];
  logic [31:0] exp_ord [6];
  int          ngot;
  int          exp_y [4];

  initial begin
    for (int i = 0; i < 3; i++) begin
      clr_req(i);
      ydr[i] = 2'b11;
    end
    s_qdready = 2'b11;
    s_yvalid = 1'b0; s_ylast = 1'b0; s_ywreply = 1'b0;
    s_yresp = 2'b00; s_yrdata = '0; s_yburden = 1'b0;
    rstnn = 1'b0;
    qv[0] = 1'b1;
    tick; tick;
    settle;
    chk("rst_s_qvalid", s_qvalid, 1'b0);
    chk("rst_s_ydready", s_ydready, 2'b00);
    chk("rst_qdready", qdr_any(), 3'b000);
    chk("rst_yvalid", yvec(), 3'b000);
    clr_req(0);
    rstnn = 1'b1;
    tick;

    // All three requesters read continuously; slave answers each immediately
    set_read(0, 32'h100); set_read(1, 32'h200); set_read(2, 32'h300);
    s_yvalid = 1'b1; s_ylast = 1'b1;
    ngot = 0;
    for (int cyc = 0; cyc < 40 && ngot < 6; cyc++) begin
      settle;
      if (s_qvalid) begin
        got[ngot] = s_qaddr;
        ngot++;
      end
      tick;
    end
    for (int i = 0; i < 3; i++) clr_req(i);
    chk("arb_grants", ngot, 6);
`ifdef DCA_MATRIX_SLX_ARB_RR_EN
    exp_ord = '{32'h100, 32'h200, 32'h300, 32'h100, 32'h200, 32'h300};
`else
    exp_ord = '{32'h100, 32'h100, 32'h100, 32'h100, 32'h100, 32'h100};
`endif
    for (int i = 0; i < 6; i++) chk($sformatf("arb_order%0d", i), got[i], exp_ord[i]);
    tick; tick; tick;
    s_yvalid = 1'b0; s_ylast = 1'b0;
    tick;

    // Single read by mb with a two-beat response
    set_read(1, 32'h1000);
    settle;
    chk("rd_idle_qvalid", s_qvalid, 1'b0);
    tick;
    settle;
    chk("rd_qvalid", s_qvalid, 1'b1);
    chk("rd_addr", s_qaddr, 32'h1000);
    chk("rd_mb_qdready", qdr[1], 2'b11);
    chk("rd_ma_qdready", qdr[0], 2'b00);
    tick;
    clr_req(1);
    settle;
    chk("rd_after_qvalid", s_qvalid, 1'b0);
    s_yvalid = 1'b1; s_ylast = 1'b0; s_yrdata = 128'hAAAA;
    settle;
    chk("rd_beat0_yvalid", yvec(), 3'b010);
    chk("rd_beat0_data", yrdata[1], 128'hAAAA);
    chk("rd_ydready", s_ydready, 2'b11);
    tick;
    s_ylast = 1'b1; s_yrdata = 128'hBBBB;
    settle;
    chk("rd_beat1_yvalid", yvec(), 3'b010);
    chk("rd_beat1_last", yl[1], 1'b1);
    tick;
    settle;
    chk("rd_empty_yvalid", yvec(), 3'b000);
    chk("rd_empty_ydready", s_ydready, 2'b00);
    s_yvalid = 1'b0; s_ylast = 1'b0;
    tick;

    // mc four-beat write holds the grant while ma waits
    qv[2] = 1'b1; qw[2] = 1'b1; ql[2] = 1'b0; qlen[2] = 8'd3; qsize[2] = 3'd4;
    qburst[2] = 2'd1; qwstrb[2] = 16'hFFFF; qwdata[2] = 128'hD0; qaddr[2] = 32'h3000;
    qburden[2] = 1'b1;
    tick;
    set_read(0, 32'h4000);
    settle;
    chk("wr_mc_qdready", qdr[2], 2'b11);
    chk("wr_ma_qdready0", qdr[0], 2'b00);
    chk("wr_qwrite", s_qwrite, 1'b1);
    chk("wr_qlen", s_qlen, 8'd3);
    chk("wr_desc", {s_qsize, s_qburst, s_qwstrb, s_qburden}, {3'd4, 2'd1, 16'hFFFF, 1'b1});
    chk("wr_data0", s_qwdata, 128'hD0);
    for (int b = 1; b < 4; b++) begin
      tick;
      qwdata[2] = 128'hD0 + 128'(b);
      ql[2] = (b == 3);
      settle;
      chk($sformatf("wr_ma_hold%0d", b), qdr[0], 2'b00);
      chk($sformatf("wr_data%0d", b), s_qwdata, 128'hD0 + 128'(b));
      chk($sformatf("wr_last%0d", b), s_qlast, (b == 3));
    end
    tick;
    clr_req(2);
    settle;
    chk("wr_bubble_qvalid", s_qvalid, 1'b0);
    chk("wr_bubble_ma", qdr[0], 2'b00);
    tick;
    settle;
    chk("wr_ma_grant", s_qvalid, 1'b1);
    chk("wr_ma_addr", s_qaddr, 32'h4000);
    chk("wr_ma_qdready", qdr[0], 2'b11);
    tick;
    clr_req(0);

    // Drain: write reply to mc (with backpressure), then read data to ma
    s_yvalid = 1'b1; s_ywreply = 1'b1; s_ylast = 1'b1; s_yresp = 2'b00;
    ydr[2] = 2'b01;
    settle;
    chk("wrep_yvalid", yvec(), 3'b100);
    chk("wrep_flag", ywr[2], 1'b1);
    chk("wrep_bp_ydready", s_ydready, 2'b01);
    tick;
    settle;
    chk("wrep_bp_hold", yvec(), 3'b100);
    ydr[2] = 2'b11;
    tick;
    s_ywreply = 1'b0; s_yresp = 2'b01; s_yburden = 1'b1;
    settle;
    chk("rdrsp_yvalid", yvec(), 3'b001);
    chk("rdrsp_resp", {yresp[0], yburden[0]}, {2'b01, 1'b1});
    tick;
    s_yvalid = 1'b0; s_ylast = 1'b0; s_yresp = 2'b00; s_yburden = 1'b0;

    // Fill the queue: a, c, b, a
    issue_read(0, 32'h5000);
    issue_read(2, 32'h6000);
    issue_read(1, 32'h7000);
    issue_read(0, 32'h5100);
    set_read(1, 32'h7100);
    for (int c = 0; c < 3; c++) begin
      settle;
      chk($sformatf("full_block%0d", c), s_qvalid, 1'b0);
      chk($sformatf("full_qdready%0d", c), qdr[1], 2'b00);
      tick;
    end
    s_yvalid = 1'b1; s_ylast = 1'b1; s_yrdata = 128'hD1;
    settle;
    chk("full_pop_a", yvec(), 3'b001);
    tick;
    s_yvalid = 1'b0;
    settle;
    chk("full_post_pop_idle", s_qvalid, 1'b0);
    tick;
    s_yvalid = 1'b1; s_yrdata = 128'hD2;
    settle;
    chk("pp_grant_b", s_qvalid, 1'b1);
    chk("pp_addr", s_qaddr, 32'h7100);
    chk("pp_pop_c", yvec(), 3'b100);
    chk("pp_data_c", yrdata[2], 128'hD2);
    tick;
    clr_req(1);
    s_yvalid = 1'b0;
    // Count must still be 3: one more read fits, the next is blocked
    issue_read(0, 32'h5200);
    set_read(2, 32'h6100);
    settle;
    chk("cnt_block0", s_qvalid, 1'b0);
    tick;
    settle;
    chk("cnt_block1", s_qvalid, 1'b0);
    chk("cnt_block_qdready", qdr[2], 2'b00);
    clr_req(2);
    exp_y = '{1, 0, 1, 0};
    s_yvalid = 1'b1; s_ylast = 1'b1;
    for (int r = 0; r < 4; r++) begin
      settle;
      chk($sformatf("order%0d", r), yvec(), 3'(1 << exp_y[r]));
      tick;
    end
    settle;
    chk("order_empty_yvalid", yvec(), 3'b000);
    chk("order_empty_ydready", s_ydready, 2'b00);
    s_yvalid = 1'b0; s_ylast = 1'b0;
    tick;

    // Reset in the middle of a write burst with a response in progress
    issue_read(0, 32'h8000);
    s_yvalid = 1'b1; s_ylast = 1'b0;
    settle;
    chk("rstm_yvalid_pre", yvec(), 3'b001);
    qv[2] = 1'b1; qw[2] = 1'b1; ql[2] = 1'b0; qlen[2] = 8'd3; qaddr[2] = 32'h9000;
    tick;
    settle;
    chk("rstm_mc_grant", qdr[2], 2'b11);
    tick;
    settle;
    rstnn = 1'b0;
    #1;
    chk("rstm_s_qvalid", s_qvalid, 1'b0);
    chk("rstm_qdready", qdr_any(), 3'b000);
    chk("rstm_yvalid", yvec(), 3'b000);
    chk("rstm_ydready", s_ydready, 2'b00);
    tick;
    rstnn = 1'b1;
    clr_req(2);
    s_yvalid = 1'b0;
    set_read(1, 32'hA000);
    settle;
    chk("post_rst_idle", s_qvalid, 1'b0);
    tick;
    settle;
    chk("post_rst_grant", s_qvalid, 1'b1);
    chk("post_rst_addr", s_qaddr, 32'hA000);
    tick;
    clr_req(1);
    tick;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/dca_matrix_slx_arbiter.md
# dca_matrix_slx_arbiter

Shares one SLX memory port among the three matrix load/store requesters (ma, mb, mc) of the DCA matrix MAC. It sits between the MAC's three SLX master ports and the single SLX slave port toward the system interconnect. It arbitrates the request channel at packet granularity and keeps an ordered ID queue so that each response returns to the requester that issued it. Responses return in order; the slave side is in-order per port.

## Interface
Parameters:
- BW_ADDR, 32, address width
- BW_DATA, 128, data width for all four ports
- BW_BURDEN, 1, burden width, passed through untouched
- OUTSTANDING_DEPTH, 4, ID queue depth and maximum number of packets in flight (power of two, ≥2)

Ports (X ∈ {a,b,c}, one identical group per requester):
- clk  input  1  single clock
- rstnn  input  1  asynchronous active-low reset
- mX_slxqvalid  input  1  request beat valid
- mX_slxqlast  input  1  last beat of packet
- mX_slxqwrite  input  1  1 = write packet
- mX_slxqlen / qsize / qburst  input  8/3/2  burst descriptors
- mX_slxqwstrb / qwdata / qaddr / qburden  input  BW_DATA/8 / BW_DATA / BW_ADDR / BW_BURDEN  payload
- mX_slxqdready  output  2  [0] read-command ready, [1] write-beat ready
- mX_slxyvalid / ylast / ywreply  output  1 each  response beat, last beat, write-reply flag
- mX_slxyresp / yrdata / yburden  output  2 / BW_DATA / BW_BURDEN  response payload
- mX_slxydready  input  2  [0] read-data ready, [1] write-reply ready
- s_slxq*  output  (same widths)  request toward slave; s_slxqdready is an input
- s_slxy*  input  (same widths)  response from slave; s_slxydready is an output

## Operation
- Request beat transfer: qvalid && qdready[qwrite]. Response beat transfer: yvalid && ydready[ywreply].
- States: IDLE, GRANT.
- IDLE: if the ID queue is not full and any mX_slxqvalid = 1, pick a winner. Register grant[1:0] (0=a, 1=b, 2=c). Go to GRANT.
- GRANT: the winner's q-channel is wired straight to s_slxq*. The other requesters see qdready = 0.
  - On a transferred beat with qlast = 1: push the grant ID into the queue and return to IDLE.
  - A read command is one beat with qlast = 1. A write packet holds the grant through all its beats.
- Response routing: the queue head selects the requester. s_slxy* fan out to that requester only; all other mX_slxyvalid = 0. s_slxydready = head requester's ydready.
  - Pop on a transferred beat with (ywreply = 1) or (ylast = 1).
- Queue empty: s_slxydready = 0 and all mX_slxyvalid = 0. A response arriving in this state stalls indefinitely.
- Push and pop in the same cycle: both happen, and the count is unchanged.
- Grant is blocked while count == OUTSTANDING_DEPTH. There is exactly one push per grant, so no overflow can occur.

## Timing
- Reset values:
  - s_slxqvalid = 0, s_slxydready = 0.
  - All mX_slxqdready = 0, all mX_slxyvalid = 0.
  - State IDLE, queue empty, round-robin pointer = a has highest priority.
- Arbitration latency: a request seen in IDLE at cycle n appears on s_slxqvalid at cycle n+1.
- Back-to-back packets: the cycle after the last beat is an IDLE cycle. Minimum spacing is 1 bubble.
- Response path: zero-latency combinational from s_slxy* to mX_slxy*. The pop is registered, so the new head takes effect the next cycle.
- A requester must hold qvalid and its payload stable until the beat transfers.
- Reset asserted mid-packet or mid-response: all state clears immediately. In-flight transactions are lost; the system resets the slave and the requesters together.

## Configuration
- DCA_MATRIX_SLX_ARB_RR_EN defined: round-robin arbitration.
  - The pointer advances to the requester after the winner on each grant. Scan order a→b→c→a starting from the pointer.
- Not defined: fixed priority, a > b > c. The pointer register is not built.

## Test plan
- Single read by mb, addr 0x1000: s_slxqvalid rises 1 cycle after mb_slxqvalid. Slave returns 2 beats with ylast on the 2nd. Only mb_slxyvalid toggles. Queue empty afterwards.
- ma, mb, mc all request single-beat reads continuously, with RR_EN: grant order a, b, c, a, b, c. Without RR_EN: a wins every grant while ma stays valid.
- mc issues a 4-beat write (qlen = 3) while ma requests: ma_slxqdready stays 0 until mc's qlast beat transfers. ma is granted on the following IDLE cycle.
- Slave withholds responses: after 4 granted reads (OUTSTANDING_DEPTH = 4), a 5th request gets no grant. The first read-data beat with ylast pops the queue, and the grant follows the next cycle.
- Simultaneous push and pop with count = 3: count stays 3. Responses return in order a, c, b matching the issue order.
- rstnn pulsed low during a write burst:
  - s_slxqvalid and all qdready/yvalid go 0 asynchronously.
  - After release, the first request is granted in normal IDLE→GRANT fashion.
